// File: rtl/fifo_word_serializer_if.sv
// FIFO read port and serial valid/ready stream bundled between the serializer
// (master) and the FIFO/downstream link side (slave).
interface fifo_word_serializer_if #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_cs;
  logic                  fifo_rd_en;

  logic                  ser_ready;
  logic                  ser_valid;
  logic                  ser_bit;
  logic                  ser_first;
  logic                  ser_last;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    input  ser_ready,
    output fifo_cs,
    output fifo_rd_en,
    output ser_valid,
    output ser_bit,
    output ser_first,
    output ser_last
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    output ser_ready,
    input  fifo_cs,
    input  fifo_rd_en,
    input  ser_valid,
    input  ser_bit,
    input  ser_first,
    input  ser_last
  );

endinterface

// File: rtl/fifo_word_serializer.sv
// Pops words from a synchronous FIFO and shifts them out bit-serially on a
// valid/ready stream with first/last framing and a completed-word counter.
module fifo_word_serializer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  fifo_word_serializer_if.master bus,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  word_count
);

  localparam int unsigned BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    LOAD  = 2'd2,
    SHIFT = 2'd3
  } state_e;

  state_e                 state_q;
  state_e                 state_d;

  logic [DATA_WIDTH-1:0]  shreg_q;
  logic [DATA_WIDTH-1:0]  shreg_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q;
  logic [BIT_CNT_W-1:0]   bit_cnt_d;
  logic [CNT_WIDTH-1:0]   word_count_q;
  logic [CNT_WIDTH-1:0]   word_count_d;

  logic                   fifo_cs_q;
  logic                   fifo_cs_d;
  logic                   ser_valid_q;
  logic                   ser_valid_d;
  logic                   ser_first_q;
  logic                   ser_first_d;
  logic                   ser_last_q;
  logic                   ser_last_d;
  logic                   busy_q;
  logic                   busy_d;

  logic                   can_pop;
  logic                   xfer;
  logic                   last_xfer;

  // fifo_empty only matters where a pop decision is made (IDLE, last bit).
  assign can_pop   = enable && !bus.fifo_empty;
  assign xfer      = (state_q == SHIFT) && bus.ser_ready;
  assign last_xfer = xfer && (bit_cnt_q == LAST_BIT);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (can_pop) state_d = REQ;
      REQ:     state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (last_xfer) state_d = can_pop ? REQ : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shift register, bit counter and word counter next values
  always_comb begin
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    word_count_d = word_count_q;
    if (state_q == LOAD) begin
      shreg_d   = bus.fifo_data;
      bit_cnt_d = '0;
    end else if (xfer) begin
      shreg_d   = MSB_FIRST ? {shreg_q[DATA_WIDTH-2:0], 1'b0}
                            : {1'b0, shreg_q[DATA_WIDTH-1:1]};
      bit_cnt_d = last_xfer ? '0 : bit_cnt_q + BIT_CNT_W'(1);
    end
    if (last_xfer) begin
      word_count_d = word_count_q + CNT_WIDTH'(1);
    end
  end

  // Output logic: next values of the registered outputs, decoded from state_d
  always_comb begin
    fifo_cs_d   = 1'b0;
    ser_valid_d = 1'b0;
    ser_first_d = 1'b0;
    ser_last_d  = 1'b0;
    busy_d      = 1'b0;
    fifo_cs_d   = (state_d == REQ);
    ser_valid_d = (state_d == SHIFT);
    ser_first_d = ser_valid_d && (bit_cnt_d == '0);
    ser_last_d  = ser_valid_d && (bit_cnt_d == LAST_BIT);
    busy_d      = (state_d != IDLE);
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      word_count_q <= '0;
    end else begin
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      word_count_q <= word_count_d;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_cs_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_first_q <= 1'b0;
      ser_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      fifo_cs_q   <= fifo_cs_d;
      ser_valid_q <= ser_valid_d;
      ser_first_q <= ser_first_d;
      ser_last_q  <= ser_last_d;
      busy_q      <= busy_d;
    end
  end

  // The outgoing bit is the live end of the shift register; it drains to zero
  // once a word completes, so ser_bit reads 0 whenever ser_valid is low.
  assign bus.ser_bit    = MSB_FIRST ? shreg_q[DATA_WIDTH-1] : shreg_q[0];
  assign bus.fifo_cs    = fifo_cs_q;
  assign bus.fifo_rd_en = fifo_cs_q;
  assign bus.ser_valid  = ser_valid_q;
  assign bus.ser_first  = ser_first_q;
  assign bus.ser_last   = ser_last_q;
  assign busy           = busy_q;
  assign word_count     = word_count_q;

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Directed bench: MSB-first and LSB-first serializers, each fed by a small
// FIFO model with one cycle of read latency.
`timescale 1ns/1ps
module tb_fifo_word_serializer;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic en_m  = 1'b0;
  logic en_l  = 1'b0;
  logic ready = 1'b0;

  logic          busy_m;
  logic          busy_l;
  logic [CW-1:0] wc_m;
  logic [CW-1:0] wc_l;

  fifo_word_serializer_if #(.DATA_WIDTH(DW)) ifm ();
  fifo_word_serializer_if #(.DATA_WIDTH(DW)) ifl ();

  fifo_word_serializer #(.DATA_WIDTH(DW), .MSB_FIRST(1'b1), .CNT_WIDTH(CW)) dut_m (
    .clk(clk), .rst(rst), .enable(en_m), .bus(ifm), .busy(busy_m), .word_count(wc_m)
  );

  fifo_word_serializer #(.DATA_WIDTH(DW), .MSB_FIRST(1'b0), .CNT_WIDTH(CW)) dut_l (
    .clk(clk), .rst(rst), .enable(en_l), .bus(ifl), .busy(busy_l), .word_count(wc_l)
  );

  always #5 clk = ~clk;

  // FIFO models
  logic [DW-1:0] mem_m [16];
  logic [DW-1:0] mem_l [16];
  int wr_m = 0, rd_m = 0, unf_m = 0;
  int wr_l = 0, rd_l = 0;

  assign ifm.fifo_empty = (wr_m == rd_m);
  assign ifl.fifo_empty = (wr_l == rd_l);
  assign ifm.ser_ready  = ready;
  assign ifl.ser_ready  = ready;

  always @(posedge clk) begin
    if (ifm.fifo_cs && ifm.fifo_rd_en) begin
      if (wr_m != rd_m) begin
        ifm.fifo_data <= mem_m[rd_m % 16];
        rd_m <= rd_m + 1;
      end else begin
        unf_m <= unf_m + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (ifl.fifo_cs && ifl.fifo_rd_en && (wr_l != rd_l)) begin
      ifl.fifo_data <= mem_l[rd_l % 16];
      rd_l <= rd_l + 1;
    end
  end

  // Monitors sample on the falling edge; entries are {first, last, bit}
  int         cyc = 0, cs_err = 0, busy_cnt_m = 0, hold_err = 0, rd_cnt_l = 0;
  int         rd_cyc_m [$];
  logic [2:0] xq_m [$];
  logic [2:0] xq_l [$];
  logic       stall_prev = 1'b0;
  logic [2:0] held = 3'b000;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (ifm.fifo_rd_en) rd_cyc_m.push_back(cyc);
    if (ifm.fifo_cs != ifm.fifo_rd_en) cs_err <= cs_err + 1;
    if (busy_m) busy_cnt_m <= busy_cnt_m + 1;
    if (ifm.ser_valid && stall_prev && ({ifm.ser_first, ifm.ser_last, ifm.ser_bit} != held))
      hold_err <= hold_err + 1;
    stall_prev <= ifm.ser_valid && !ready;
    held       <= {ifm.ser_first, ifm.ser_last, ifm.ser_bit};
    if (ifm.ser_valid && ready) xq_m.push_back({ifm.ser_first, ifm.ser_last, ifm.ser_bit});
  end

  always @(negedge clk) begin
    if (ifl.fifo_rd_en) rd_cnt_l <= rd_cnt_l + 1;
    if (ifl.ser_valid && ready) xq_l.push_back({ifl.ser_first, ifl.ser_last, ifl.ser_bit});
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_m(input logic [DW-1:0] w);
    mem_m[wr_m % 16] = w;
    wr_m = wr_m + 1;
  endtask

  task automatic push_l(input logic [DW-1:0] w);
    mem_l[wr_l % 16] = w;
    wr_l = wr_l + 1;
  endtask

  // Rebuild one word-long field (0 bit, 1 last, 2 first) from transfer entries
  function automatic logic [DW-1:0] pack(input logic [2:0] q [$], input int base,
                                         input int field, input bit msb);
    logic [DW-1:0] w;
    logic [2:0]    e;
    w = '0;
    for (int i = 0; i < int'(DW); i++) begin
      e = (base + i < q.size()) ? q[base + i] : 3'b000;
      w[msb ? (int'(DW) - 1 - i) : i] = e[field];
    end
    return w;
  endfunction

  function automatic logic [63:0] outs_m();
    return 64'({ifm.fifo_cs, ifm.fifo_rd_en, ifm.ser_valid, ifm.ser_bit,
                ifm.ser_first, ifm.ser_last, busy_m});
  endfunction

  int b0, r0, bc0, h0;

  initial begin
    // Reset and idle with an empty FIFO
    #2 rst = 1'b0;
    en_m  = 1'b1;
    ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", outs_m(), 64'd0);
    check("rst_word_count", 64'(wc_m), 64'd0);
    rst = 1'b1;
    repeat (20) step();
    check("idle_outputs", outs_m(), 64'd0);
    check("idle_rd_pulses", 64'(rd_cyc_m.size()), 64'd0);
    check("idle_busy_cycles", 64'(busy_cnt_m), 64'd0);

    // Single word, MSB first
    b0 = xq_m.size(); r0 = rd_cyc_m.size(); bc0 = busy_cnt_m;
    push_m(32'h0000_0001);
    for (int i = 0; i < 100 && wc_m != 16'd1; i++) step();
    repeat (3) step();
    check("single_word_count", 64'(wc_m), 64'd1);
    check("single_rd_pulses", 64'(rd_cyc_m.size() - r0), 64'd1);
    check("single_bit_count", 64'(xq_m.size() - b0), 64'd32);
    check("single_data", 64'(pack(xq_m, b0, 0, 1'b1)), 64'h0000_0001);
    check("single_first", 64'(pack(xq_m, b0, 2, 1'b1)), 64'h8000_0000);
    check("single_last", 64'(pack(xq_m, b0, 1, 1'b1)), 64'h0000_0001);
    check("single_busy_cycles", 64'(busy_cnt_m - bc0), 64'd34);

    // Back-to-back words
    b0 = xq_m.size(); r0 = rd_cyc_m.size(); bc0 = busy_cnt_m;
    push_m(32'd1); push_m(32'd10); push_m(32'd100);
    for (int i = 0; i < 200 && wc_m != 16'd4; i++) step();
    repeat (3) step();
    check("b2b_word_count", 64'(wc_m), 64'd4);
    check("b2b_rd_pulses", 64'(rd_cyc_m.size() - r0), 64'd3);
    if (rd_cyc_m.size() - r0 >= 3) begin
      check("b2b_gap_0_1", 64'(rd_cyc_m[r0 + 1] - rd_cyc_m[r0]), 64'd34);
      check("b2b_gap_1_2", 64'(rd_cyc_m[r0 + 2] - rd_cyc_m[r0 + 1]), 64'd34);
    end
    check("b2b_busy_cycles", 64'(busy_cnt_m - bc0), 64'd102);
    check("b2b_word0", 64'(pack(xq_m, b0, 0, 1'b1)), 64'd1);
    check("b2b_word1", 64'(pack(xq_m, b0 + 32, 0, 1'b1)), 64'd10);
    check("b2b_word2", 64'(pack(xq_m, b0 + 64, 0, 1'b1)), 64'd100);
    check("b2b_underflow", 64'(unf_m), 64'd0);

    // Backpressure: ready pattern 1,0,0 repeating
    b0 = xq_m.size(); h0 = hold_err;
    push_m(32'h8000_0000);
    for (int i = 0; i < 400 && wc_m != 16'd5; i++) begin
      ready = (i % 3 == 0);
      step();
    end
    ready = 1'b1;
    repeat (3) step();
    check("bp_word_count", 64'(wc_m), 64'd5);
    check("bp_hold_stable", 64'(hold_err - h0), 64'd0);
    check("bp_bit_count", 64'(xq_m.size() - b0), 64'd32);
    check("bp_data", 64'(pack(xq_m, b0, 0, 1'b1)), 64'h8000_0000);
    check("bp_first", 64'(pack(xq_m, b0, 2, 1'b1)), 64'h8000_0000);
    check("bp_last", 64'(pack(xq_m, b0, 1, 1'b1)), 64'h0000_0001);

    // LSB first with enable dropped during bit 5 of the first word
    push_l(32'h0000_0002); push_l(32'h0000_0004);
    en_l = 1'b1;
    for (int i = 0; i < 100 && xq_l.size() < 5; i++) step();
    check("lsb_reach_bit5", 64'(xq_l.size()), 64'd5);
    en_l = 1'b0;
    for (int i = 0; i < 100 && wc_l != 16'd1; i++) step();
    repeat (10) step();
    check("lsb_word_count_1", 64'(wc_l), 64'd1);
    check("lsb_rd_pulses_1", 64'(rd_cnt_l), 64'd1);
    check("lsb_busy_after_drop", 64'(busy_l), 64'd0);
    check("lsb_word1", 64'(pack(xq_l, 0, 0, 1'b0)), 64'h0000_0002);
    check("lsb_first_last", 64'({pack(xq_l, 0, 2, 1'b0), pack(xq_l, 0, 1, 1'b0)}),
          {32'h0000_0001, 32'h8000_0000});
    en_l = 1'b1;
    for (int i = 0; i < 100 && wc_l != 16'd2; i++) step();
    repeat (3) step();
    check("lsb_word_count_2", 64'(wc_l), 64'd2);
    check("lsb_rd_pulses_2", 64'(rd_cnt_l), 64'd2);
    check("lsb_word2", 64'(pack(xq_l, 32, 0, 1'b0)), 64'h0000_0004);

    // Mid-word reset during bit 10, then a fresh word
    b0 = xq_m.size();
    push_m(32'h1234_5678);
    for (int i = 0; i < 100 && (xq_m.size() - b0) < 10; i++) step();
    check("mrst_reach_bit10", 64'(xq_m.size() - b0), 64'd10);
    #2 rst = 1'b0;
    #1;
    check("mrst_outputs", outs_m(), 64'd0);
    check("mrst_word_count", 64'(wc_m), 64'd0);
    repeat (2) step();
    rst = 1'b1;
    repeat (2) step();
    b0 = xq_m.size(); r0 = rd_cyc_m.size();
    push_m(32'hC000_0003);
    for (int i = 0; i < 100 && wc_m != 16'd1; i++) step();
    repeat (3) step();
    check("mrst_after_word_count", 64'(wc_m), 64'd1);
    check("mrst_after_rd_pulses", 64'(rd_cyc_m.size() - r0), 64'd1);
    check("mrst_after_data", 64'(pack(xq_m, b0, 0, 1'b1)), 64'hC000_0003);
    check("mrst_after_first", 64'(pack(xq_m, b0, 2, 1'b1)), 64'h8000_0000);
    check("mrst_underflow", 64'(unf_m), 64'd0);
    check("cs_rd_en_agree", 64'(cs_err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
